// File: rtl/hamming_dec_pipe.sv
// Two-stage valid/ready Hamming SEC decoder: S1 latches the codeword and its syndrome,
// S2 applies the single-bit correction, extracts the data bits and keeps a saturating corrected-word count.
module hamming_dec_pipe #(
   parameter int n     = 7,
   parameter int k     = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [n-1:0]     code_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [k-1:0]     data_out,
   output logic [$clog2(n+1)-1:0] syndrome,
   output logic             err_corr,
   output logic             err_unc,
   output logic [CNT_W-1:0] corr_count
);

   localparam int P = $clog2(n + 1);

   generate
      if (k != n - P) begin : g_bad_width
         $error("hamming_dec_pipe: k must equal n - P");
      end
   endgenerate

   // Syndrome bit l collects every position whose 1-based index has bit l set.
   function automatic logic [P-1:0] calc_syn(input logic [n-1:0] c);
      logic [P-1:0] s;
      s = '0;
      for (int i = 0; i < n; i++) begin
         for (int l = 0; l < P; l++) begin
            if ((((i + 1) >> l) & 1) != 0) s[l] = s[l] ^ c[i];
         end
      end
      return s;
   endfunction

   // Data bits occupy the non-power-of-two indices, lowest index first.
   function automatic logic [k-1:0] extract(input logic [n-1:0] c);
      logic [k-1:0] d;
      int           j;
      d = '0;
      j = 0;
      for (int i = 0; i < n; i++) begin
         if (((i + 1) & i) != 0) begin
            d[j] = c[i];
            j++;
         end
      end
      return d;
   endfunction

   logic             s1_v;
   logic [n-1:0]     s1_code;
   logic [P-1:0]     s1_syn;
   logic             s2_v;
   logic             s2_adv;
   logic             in_hs;
   logic             out_hs;
   logic [31:0]      syn_w;
   logic             hit;
   logic             unc;
   logic [n-1:0]     fixed;

   assign s2_adv    = s1_v & (~s2_v | out_ready);
   assign in_ready  = ~s1_v | s2_adv;
   assign in_hs     = in_valid & in_ready;
   assign out_hs    = s2_v & out_ready;
   assign out_valid = s2_v;

   // Correction flips only the addressed bit; out-of-range syndromes leave the word untouched.
   always_comb begin
      syn_w = 32'(s1_syn);
      hit   = (syn_w != 32'd0) && (syn_w <= 32'(n));
      unc   = syn_w > 32'(n);
      fixed = s1_code;
      for (int i = 0; i < n; i++) begin
         if (hit && (syn_w == 32'(i + 1))) fixed[i] = ~s1_code[i];
      end
   end

   // Stage 1 refills on any input handshake, otherwise empties when its word moves on.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_v    <= 1'b0;
         s1_code <= '0;
         s1_syn  <= '0;
      end else if (in_hs) begin
         s1_v    <= 1'b1;
         s1_code <= code_in;
         s1_syn  <= calc_syn(code_in);
      end else if (s2_adv) begin
         s1_v    <= 1'b0;
      end
   end

   // Stage 2 outputs only change on advance, so they hold while downstream stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_v     <= 1'b0;
         data_out <= '0;
         syndrome <= '0;
         err_corr <= 1'b0;
         err_unc  <= 1'b0;
      end else if (s2_adv) begin
         s2_v     <= 1'b1;
         data_out <= extract(fixed);
         syndrome <= s1_syn;
         err_corr <= hit;
         err_unc  <= unc;
      end else if (out_hs) begin
         s2_v     <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         corr_count <= '0;
      end else if (out_hs && err_corr && (corr_count != {CNT_W{1'b1}})) begin
         corr_count <= corr_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hamming_dec_pipe.sv
// Directed bench for hamming_dec_pipe: three instances (n=7, n=12, n=7 with 2-bit counter)
// share clock, reset and handshake inputs so one linear sequence drives them all.
module tb_hamming_dec_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [6:0]  code_a, code_c;
   logic [11:0] code_b;

   logic        ready_a, ready_b, ready_c;
   logic        ovalid_a, ovalid_b, ovalid_c;
   logic [3:0]  data_a, data_c;
   logic [7:0]  data_b;
   logic [2:0]  syn_a, syn_c;
   logic [3:0]  syn_b;
   logic        corr_a, corr_b, corr_c;
   logic        unc_a, unc_b, unc_c;
   logic [15:0] cnt_a, cnt_b;
   logic [1:0]  cnt_c;

   int nAssert = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   hamming_dec_pipe #(.n(7), .k(4), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready_a), .code_in(code_a),
      .out_valid(ovalid_a), .out_ready(out_ready), .data_out(data_a), .syndrome(syn_a),
      .err_corr(corr_a), .err_unc(unc_a), .corr_count(cnt_a));

   hamming_dec_pipe #(.n(12), .k(8), .CNT_W(16)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready_b), .code_in(code_b),
      .out_valid(ovalid_b), .out_ready(out_ready), .data_out(data_b), .syndrome(syn_b),
      .err_corr(corr_b), .err_unc(unc_b), .corr_count(cnt_b));

   hamming_dec_pipe #(.n(7), .k(4), .CNT_W(2)) dut_c (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ready_c), .code_in(code_c),
      .out_valid(ovalid_c), .out_ready(out_ready), .data_out(data_c), .syndrome(syn_c),
      .err_corr(corr_c), .err_unc(unc_c), .corr_count(cnt_c));

   // Stream: codes for data 1..8, the third word carries a bit-6 error.
   logic [6:0] sCode [8] = '{7'h07, 7'h19, 7'h5E, 7'h2A, 7'h2D, 7'h33, 7'h34, 7'h4B};
   logic [3:0] sData [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offers one word to all three instances and returns the cycles until out_valid rises.
   task automatic applyStimulus(input logic [6:0] ca, input logic [11:0] cb, input logic [6:0] cc,
                                output int lat);
      int tmo;
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      code_a    = ca;
      code_b    = cb;
      code_c    = cc;
      tmo = 0;
      #1;
      while (!ready_a && tmo < 10) begin
         @(negedge clk);
         #1;
         tmo++;
      end
      checkOutput("accept", 32'(ready_a), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!ovalid_a && lat < 8) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat;
      int sent;
      int recv;
      int cyc;
      logic sawBp;
      logic held;
      logic [3:0] heldData;
      logic [2:0] heldSyn;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      code_a = '0; code_b = '0; code_c = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_out_valid", 32'(ovalid_a), 32'd0);
      checkOutput("rst_in_ready", 32'(ready_a), 32'd1);
      checkOutput("rst_count", 32'(cnt_a), 32'd0);
      checkOutput("rst_data", 32'(data_a), 32'd0);
      reset = 1'b0;

      // Clean word on a, double error on b, single error on c.
      applyStimulus(7'h55, 12'h090, 7'h45, lat);
      checkOutput("latency", 32'(lat), 32'd2);
      checkOutput("a_data", 32'(data_a), 32'hB);
      checkOutput("a_syn", 32'(syn_a), 32'd0);
      checkOutput("a_corr", 32'(corr_a), 32'd0);
      checkOutput("a_unc", 32'(unc_a), 32'd0);
      checkOutput("b_syn", 32'(syn_b), 32'hD);
      checkOutput("b_unc", 32'(unc_b), 32'd1);
      checkOutput("b_corr", 32'(corr_b), 32'd0);
      checkOutput("b_data", 32'(data_b), 32'h02);
      checkOutput("c_syn", 32'(syn_c), 32'h5);
      checkOutput("c_data", 32'(data_c), 32'hB);
      checkOutput("c_corr", 32'(corr_c), 32'd1);
      @(negedge clk);
      checkOutput("drain_out_valid", 32'(ovalid_a), 32'd0);
      checkOutput("c_count_1", 32'(cnt_c), 32'd1);
      checkOutput("a_count_clean", 32'(cnt_a), 32'd0);
      checkOutput("b_count_unc", 32'(cnt_b), 32'd0);

      applyStimulus(7'h45, 12'h000, 7'h55, lat);
      checkOutput("a_err_latency", 32'(lat), 32'd2);
      checkOutput("a_err_syn", 32'(syn_a), 32'h5);
      checkOutput("a_err_data", 32'(data_a), 32'hB);
      checkOutput("a_err_corr", 32'(corr_a), 32'd1);
      checkOutput("b_clean_data", 32'(data_b), 32'h00);
      @(negedge clk);
      checkOutput("a_count_1", 32'(cnt_a), 32'd1);
      checkOutput("c_count_hold", 32'(cnt_c), 32'd1);

      // Saturation on c: parity-position and data-position errors.
      applyStimulus(7'h55, 12'h000, 7'h54, lat);
      checkOutput("c_par_syn", 32'(syn_c), 32'd1);
      checkOutput("c_par_corr", 32'(corr_c), 32'd1);
      checkOutput("c_par_data", 32'(data_c), 32'hB);
      @(negedge clk);
      checkOutput("c_count_2", 32'(cnt_c), 32'd2);
      applyStimulus(7'h55, 12'h000, 7'h57, lat);
      checkOutput("c_syn2", 32'(syn_c), 32'd2);
      @(negedge clk);
      checkOutput("c_count_3", 32'(cnt_c), 32'd3);
      applyStimulus(7'h55, 12'h000, 7'h5D, lat);
      checkOutput("c_syn4", 32'(syn_c), 32'd4);
      @(negedge clk);
      checkOutput("c_count_sat1", 32'(cnt_c), 32'd3);
      applyStimulus(7'h55, 12'h000, 7'h75, lat);
      checkOutput("c_syn6", 32'(syn_c), 32'd6);
      checkOutput("c_fix_data", 32'(data_c), 32'hB);
      @(negedge clk);
      checkOutput("c_count_sat2", 32'(cnt_c), 32'd3);
      checkOutput("a_count_still1", 32'(cnt_a), 32'd1);

      // Back-to-back stream with a 3-cycle downstream stall.
      sent = 0; recv = 0; cyc = 0; sawBp = 1'b0; held = 1'b0;
      heldData = '0; heldSyn = '0;
      while (recv < 8 && cyc < 60) begin
         @(negedge clk);
         if (held && ovalid_a) begin
            checkOutput("stall_data", 32'(data_a), 32'(heldData));
            checkOutput("stall_syn", 32'(syn_a), 32'(heldSyn));
         end
         out_ready = !(cyc >= 3 && cyc <= 5);
         in_valid  = (sent < 8);
         code_a    = (sent < 8) ? sCode[sent] : 7'h00;
         code_c    = code_a;
         code_b    = 12'h000;
         #1;
         if (!ready_a) sawBp = 1'b1;
         held = ovalid_a && !out_ready;
         heldData = data_a;
         heldSyn  = syn_a;
         if (in_valid && ready_a) sent++;
         if (ovalid_a && out_ready) begin
            checkOutput($sformatf("stream_word%0d", recv), 32'(data_a), 32'(sData[recv]));
            recv++;
         end
         cyc++;
      end
      checkOutput("stream_count", 32'(recv), 32'd8);
      checkOutput("stream_backpressure", 32'(sawBp), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("stream_drained", 32'(ovalid_a), 32'd0);
      checkOutput("a_count_2", 32'(cnt_a), 32'd2);

      // Fill both stages behind a stalled output, then reset mid-cycle.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      code_a = 7'h55; code_b = 12'h000; code_c = 7'h45;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      #1;
      checkOutput("full_in_ready", 32'(ready_a), 32'd0);
      checkOutput("full_out_valid", 32'(ovalid_a), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_out_valid", 32'(ovalid_a), 32'd0);
      checkOutput("async_count_a", 32'(cnt_a), 32'd0);
      checkOutput("async_count_c", 32'(cnt_c), 32'd0);
      checkOutput("async_in_ready", 32'(ready_a), 32'd1);
      checkOutput("async_syn", 32'(syn_c), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checkOutput("no_stale", 32'(ovalid_a | ovalid_c), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
